// File: rtl/mips32_prog_loader.sv
// Program loader: turns a framed byte stream into instruction memory writes
// and releases the MIPS32 core once the frame checksum verifies.
module mips32_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_run,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CKSUM, S_RUN, S_ERR
   } state_t;

   state_t      state, nxt;
   logic [15:0] cnt;
   logic [15:0] idx;
   logic [1:0]  bcnt;
   logic [31:0] sh;
   logic [7:0]  chk;
   logic        acc;
   logic        idle_like;
   logic [16:0] hdr_cnt;
   logic        last_word;

   assign acc       = in_valid & in_ready;
   assign idle_like = (state == S_IDLE) || (state == S_RUN) ||
                      (state == S_ERR);
   assign hdr_cnt   = {1'b0, cnt[15:8], in_data};
   assign last_word = (bcnt == 2'd3) && ((idx + 16'd1) == cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE, S_RUN, S_ERR:
            if (start) nxt = S_HDR0;
         S_HDR0:
            if (acc) nxt = S_HDR1;
         S_HDR1:
            if (acc) begin
               if (hdr_cnt > 17'(DEPTH - BASE)) nxt = S_ERR;
               else if (hdr_cnt == 17'd0)       nxt = S_CKSUM;
               else                             nxt = S_DATA;
            end
         S_DATA:
            if (acc && last_word) nxt = S_CKSUM;
         S_CKSUM:
            if (acc) nxt = (in_data == chk) ? S_RUN : S_ERR;
         default:
            nxt = S_IDLE;
      endcase
   end

   // handshake side is a pure function of state
   always_comb begin
      in_ready = 1'b0;
      core_run = 1'b0;
      load_err = 1'b0;
      unique case (state)
         S_HDR0, S_HDR1, S_DATA, S_CKSUM: in_ready = 1'b1;
         S_RUN:                           core_run = 1'b1;
         S_ERR:                           load_err = 1'b1;
         default:                         ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         bcnt      <= '0;
         sh        <= '0;
         chk       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         load_done <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         if (idle_like && start) begin
            chk  <= '0;
            idx  <= '0;
            bcnt <= '0;
            sh   <= '0;
         end
         if (acc) begin
            unique case (state)
               S_HDR0: begin
                  cnt[15:8] <= in_data;
                  chk       <= chk ^ in_data;
               end
               S_HDR1: begin
                  cnt[7:0] <= in_data;
                  chk      <= chk ^ in_data;
               end
               S_DATA: begin
                  chk  <= chk ^ in_data;
                  sh   <= {sh[23:0], in_data};
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= ADDR_W'(BASE) + idx[ADDR_W-1:0];
                     mem_wdata <= {sh[23:0], in_data};
                     idx       <= idx + 16'd1;
                  end
               end
               S_CKSUM:
                  if (in_data == chk) load_done <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader with a write scoreboard.
module tb_mips32_prog_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_run;
   logic              load_done;
   logic              load_err;

   int tests = 0;
   int fails = 0;
   int nwr   = 0;

   logic [41:0] expq[$];
   logic [31:0] prog[$];

   mips32_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .BASE(0)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_run(core_run), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && mem_we) begin
         logic [41:0] e;
         nwr++;
         if (expq.size() == 0) begin
            chk("unexpected_write", {22'd0, mem_addr}, 32'hffffffff);
         end else begin
            e = expq.pop_front();
            chk("wr_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
            chk("wr_data", mem_wdata, e[31:0]);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bit r;
      int n;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      forever begin
         r = in_ready;
         @(posedge clk); #1;
         if (r) break;
         n++;
         if (n > 50) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // sends header + first n words of prog; chk byte xored with bad
   task automatic frame(input int n, input bit gaps, input logic [7:0] bad);
      logic [7:0] x;
      logic [7:0] hi, lo;
      logic [31:0] w;
      hi = 8'(n >> 8);
      lo = 8'(n);
      x  = hi ^ lo;
      send(hi, gaps ? $urandom_range(0, 2) : 0);
      send(lo, gaps ? $urandom_range(0, 2) : 0);
      for (int i = 0; i < n; i++) begin
         w = prog[i];
         expq.push_back({10'(i), w});
         for (int k = 3; k >= 0; k--) begin
            x = x ^ w[8*k +: 8];
            send(w[8*k +: 8], gaps ? $urandom_range(0, 3) : 0);
         end
      end
      send(x ^ bad, gaps ? $urandom_range(0, 2) : 0);
   endtask

   initial begin
      int w0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_run", {31'd0, core_run}, 32'd0);
      chk("rst_err", {31'd0, load_err}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // single word, exact timing
      pulse_start();
      chk("hdr0_ready", {31'd0, in_ready}, 32'd1);
      prog = '{32'h2801000a};
      send(8'h00, 0); send(8'h01, 0);
      send(8'h28, 0); send(8'h01, 0); send(8'h00, 0);
      expq.push_back({10'd0, 32'h2801000a});
      w0 = nwr;
      send(8'h0a, 0);
      chk("we_latency", {31'd0, mem_we}, 32'd1);
      chk("we_addr", {22'd0, mem_addr}, 32'd0);
      send(8'h22, 0);
      chk("done_pulse", {31'd0, load_done}, 32'd1);
      chk("run_high", {31'd0, core_run}, 32'd1);
      chk("run_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("done_once", {31'd0, load_done}, 32'd0);
      @(negedge clk);
      chk("single_writes", nwr - w0, 32'd1);

      // start in RUN drops core_run at once; bad checksum
      pulse_start();
      chk("run_exit", {31'd0, core_run}, 32'd0);
      chk("run_exit_rdy", {31'd0, in_ready}, 32'd1);
      w0 = nwr;
      frame(1, 1'b0, 8'h01);
      chk("bad_err", {31'd0, load_err}, 32'd1);
      chk("bad_run", {31'd0, core_run}, 32'd0);
      chk("bad_done", {31'd0, load_done}, 32'd0);
      @(negedge clk);
      chk("bad_writes", nwr - w0, 32'd1);

      // recover from ERR with good frame
      pulse_start();
      chk("err_exit", {31'd0, load_err}, 32'd0);
      frame(1, 1'b0, 8'h00);
      chk("recover_run", {31'd0, core_run}, 32'd1);

      // full program with random gaps
      prog = '{32'h2801000a, 32'h28020014, 32'h28030019,
               32'h00222000, 32'h00832800, 32'h0c000000,
               32'h00000000, 32'h00000000, 32'hfc000000};
      pulse_start();
      w0 = nwr;
      frame(9, 1'b1, 8'h00);
      chk("prog_run", {31'd0, core_run}, 32'd1);
      @(negedge clk);
      chk("prog_writes", nwr - w0, 32'd9);

      // zero count
      pulse_start();
      w0 = nwr;
      frame(0, 1'b0, 8'h00);
      chk("zero_run", {31'd0, core_run}, 32'd1);
      @(negedge clk);
      chk("zero_writes", nwr - w0, 32'd0);

      // oversize count 0x0401
      pulse_start();
      w0 = nwr;
      send(8'h04, 0); send(8'h01, 0);
      chk("over_err", {31'd0, load_err}, 32'd1);
      chk("over_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("over_writes", nwr - w0, 32'd0);

      // start during DATA is ignored; reset mid-word
      pulse_start();
      send(8'h00, 0); send(8'h02, 0);
      send(8'haa, 0); send(8'hbb, 0);
      pulse_start();
      chk("busy_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b1; #1;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
      chk("mid_rst_err", {31'd0, load_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      prog = '{32'h11223344, 32'h55667788};
      pulse_start();
      w0 = nwr;
      send(8'h00, 0); send(8'h02, 0);
      expq.push_back({10'd0, 32'h11223344});
      send(8'h11, 0); send(8'h22, 0);
      pulse_start();
      send(8'h33, 0); send(8'h44, 0);
      expq.push_back({10'd1, 32'h55667788});
      send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
      send(8'h00 ^ 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^
           8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 0);
      chk("busy_run", {31'd0, core_run}, 32'd1);
      @(negedge clk);
      chk("fresh_writes", nwr - w0, 32'd2);
      chk("queue_empty", expq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Upstream feeder for the pipelined MIPS32 core.
- Receives a framed byte stream carrying a program image and assembles it into 32-bit big-endian instruction words.
- Writes each word into instruction memory through a single write port.
- Releases the core only after the frame checksum verifies, replacing the bench-side direct Mem/PC/HALTED pokes with a hardware load path.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 1024, number of instruction memory words available.
- BASE, 0, word address the first loaded instruction is written to.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, RUN or ERR.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  byte-stream ready; a byte transfers when in_valid & in_ready.
- in_data  input  8  stream byte.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word address for mem_we.
- mem_wdata  output  32  instruction word for mem_we.
- core_run  output  1  high means the core may fetch (drives core HALTED low, holds PC=0 while low).
- load_done  output  1  one-cycle pulse on entry to RUN.
- load_err  output  1  level, high while in ERR.

Behaviour:
- Reset: asynchronous, active-high.
  - State=IDLE; all outputs 0.
  - Word index, byte counter, shift register and checksum cleared.
  - A reset mid-load discards any partial word. Memory words already written are left untouched.
- Frame format: CNT_HI, CNT_LO, then CNT words × 4 bytes (MSB first), then CHK.
  - CHK = XOR of every preceding frame byte, header included.
- States:
  - IDLE: in_ready=0. start → HDR0; checksum and word index cleared.
  - HDR0: in_ready=1. Accepted byte → cnt[15:8] → HDR1.
  - HDR1: in_ready=1. Accepted byte → cnt[7:0].
    - If {cnt_hi,byte} > DEPTH-BASE → ERR.
    - Else if zero → CKSUM.
    - Else → DATA.
  - DATA: in_ready=1.
    - Bytes shift into a 32-bit register, MSB first.
    - On the 4th accepted byte of a word, the next cycle presents mem_we=1, mem_addr=BASE+index, mem_wdata=word, and index increments.
    - After the last word's 4th byte → CKSUM.
  - CKSUM: in_ready=1.
    - Accepted byte == running XOR → RUN, with load_done pulsed on entry.
    - Otherwise → ERR.
  - RUN: core_run=1, in_ready=0. start → HDR0 with core_run dropped the same edge.
  - ERR: load_err=1, in_ready=0, core_run=0. start → HDR0.
- Timing and handshake:
  - in_ready is combinational from state only, never from in_valid.
  - in_valid low cycles stall without state change.
  - mem_we latency is exactly 1 cycle after the completing handshake.
  - Back-to-back words may produce mem_we on consecutive 4-cycle spacing. The memory port sees at most one write per cycle.
  - The last word's write occurs in the CKSUM-entry cycle, before core_run can rise.
- start is ignored in HDR0/HDR1/DATA/CKSUM.
- Running XOR updates on every accepted byte except CHK.
- Index never wraps: the oversize count is rejected in HDR1, so mem_addr stays ≤ BASE+DEPTH-1.

Test Plan:
- Single word, happy path: start; bytes 00 01 28 01 00 0a 22 with in_valid always high → one mem_we, addr 0, data 0x2801000a, 1 cycle after byte 0x0a; load_done pulse; core_run=1.
- Bad checksum: same frame with CHK=0x23 → mem_we still fires once; load_err=1; core_run stays 0. A following start returns to HDR0 and a good frame then reaches RUN.
- Full program: the 9-word test program (0x2801000a … 0xfc000000) with correct CHK and random in_valid gaps → 9 writes at addr 0–8 in order with exact data; the core then produces R4=30, R5=55.
- Zero count and oversize:
  - Bytes 00 00 00 → RUN with no mem_we.
  - With DEPTH=1024, bytes 04 01 → ERR after CNT_LO with no mem_we and in_ready=0.
- Reset mid-word: rst after the 2nd byte of word 1 → all outputs 0, state IDLE. A fresh load writes word 0 again correctly, with no stale bytes merged.
- start while busy: pulse start during DATA → ignored; frame completes normally. start in RUN → core_run falls on that edge and in_ready rises.
